// File: rtl/secondary_sensor_conditioner_pkg.sv
// rtl/secondary_sensor_conditioner_pkg.sv - shared debounce state encoding and light bit indices
package secondary_sensor_conditioner_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } debounce_state_t;

    localparam int RYG_R = 2;
    localparam int RYG_Y = 1;
    localparam int RYG_G = 0;

    localparam logic [7:0] DETECT_MAX = 8'd255;

endpackage

// File: rtl/secondary_sensor_conditioner_sync_debounce.sv
// rtl/secondary_sensor_conditioner_sync_debounce.sv - synchroniser and debounce FSM for a raw level input
module secondary_sensor_conditioner_sync_debounce
    import secondary_sensor_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rawSensor,
    output logic sensorStable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    debounce_state_t        state;
    logic [CNT_W-1:0]       cnt;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rawSensor};
        end
    end

    // Any disagreement with the pending level drops back to the old stable state with a fresh count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= STABLE_LOW;
            cnt          <= '0;
            sensorStable <= 1'b0;
        end else begin
            case (state)
                STABLE_LOW: begin
                    cnt <= '0;
                    if (sync_out) begin
                        state <= PEND_HIGH;
                        cnt   <= CNT_W'(1);
                    end
                end
                PEND_HIGH: begin
                    if (!sync_out) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= STABLE_HIGH;
                        sensorStable <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    cnt <= '0;
                    if (!sync_out) begin
                        state <= PEND_LOW;
                        cnt   <= CNT_W'(1);
                    end
                end
                PEND_LOW: begin
                    if (sync_out) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= STABLE_LOW;
                        sensorStable <= 1'b0;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/secondary_sensor_conditioner.sv
// rtl/secondary_sensor_conditioner.sv - debounced secondary-road vehicle request latch with arrival counter
module secondary_sensor_conditioner
    import secondary_sensor_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rawSensor,
    input  logic [2:0] secondaryRoadLight_RYG,
    output logic       sensorStable,
    output logic       carWaiting,
    output logic [7:0] detectCount
);

    logic green;
    logic green_d;
    logic green_fall;
    logic stable_d;
    logic stable_rise;
    logic unused_ryg_bits;

    assign green           = secondaryRoadLight_RYG[RYG_G];
    assign unused_ryg_bits = ^secondaryRoadLight_RYG[RYG_R:RYG_Y];
    assign green_fall      = green_d & ~green;
    assign stable_rise     = sensorStable & ~stable_d;

    secondary_sensor_conditioner_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .clk          (clk),
        .reset_n      (reset_n),
        .rawSensor    (rawSensor),
        .sensorStable (sensorStable)
    );

    // Green always wins: a car arriving during green is served by it; one still present at green end re-requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            green_d     <= 1'b0;
            stable_d    <= 1'b0;
            carWaiting  <= 1'b0;
            detectCount <= 8'd0;
        end else begin
            green_d  <= green;
            stable_d <= sensorStable;
            if (green) begin
                carWaiting <= 1'b0;
            end else if (green_fall && sensorStable) begin
                carWaiting <= 1'b1;
            end else if (stable_rise) begin
                carWaiting <= 1'b1;
            end
            if (stable_rise && (detectCount != DETECT_MAX)) begin
                detectCount <= detectCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_secondary_sensor_conditioner.sv
// tb/tb_secondary_sensor_conditioner.sv - directed scoreboard bench for secondary_sensor_conditioner
module tb_secondary_sensor_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rawSensor;
    logic [2:0] ryg;
    logic       sensorStable;
    logic       carWaiting;
    logic [7:0] detectCount;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    secondary_sensor_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .rawSensor              (rawSensor),
        .secondaryRoadLight_RYG (ryg),
        .sensorStable           (sensorStable),
        .carWaiting             (carWaiting),
        .detectCount            (detectCount)
    );

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s observed=%0d expected=<none queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] v);
        push(v);
        check(tag, obs);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int p[7] = '{1, 1, 0, 1, 1, 1, 1};

    initial begin
        reset_n   = 1'b0;
        rawSensor = 1'b1;
        ryg       = 3'b100;
        step(3);
        expect_now("reset_stable", sensorStable, 0);
        expect_now("reset_carwait", carWaiting, 0);
        expect_now("reset_count", detectCount, 0);

        // Release with the sensor already high: full debounce from STABLE_LOW.
        reset_n = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            step(1);
            push(n >= 6);
            check("release_stable", sensorStable);
            push(n >= 7);
            check("release_carwait", carWaiting);
        end
        expect_now("release_count", detectCount, 1);

        // Service by green, vehicle leaves during green.
        ryg = 3'b001;
        step(1);
        expect_now("service_clear", carWaiting, 0);
        rawSensor = 1'b0;
        step(8);
        expect_now("leave_stable", sensorStable, 0);
        ryg = 3'b100;
        step(2);
        expect_now("leave_no_rerequest", carWaiting, 0);
        expect_now("leave_count", detectCount, 1);

        // Glitch of three cycles must not get through.
        rawSensor = 1'b1;
        step(3);
        rawSensor = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step(1);
            expect_now("glitch_stable", sensorStable, 0);
        end
        expect_now("glitch_carwait", carWaiting, 0);
        expect_now("glitch_count", detectCount, 1);

        // Bounce 1,1,0,1,1,1,1: the 0 restarts the count; rise at edge 9.
        for (int s = 0; s <= 12; s++) begin
            push(s >= 9);
            check("bounce_stable", sensorStable);
            push(s >= 10);
            check("bounce_carwait", carWaiting);
            rawSensor = (s < 7) ? p[s][0] : 1'b1;
            step(1);
        end
        expect_now("bounce_count", detectCount, 2);

        // Vehicle still present when green ends re-requests; yellow counts as not green.
        ryg = 3'b001;
        step(1);
        expect_now("rereq_served", carWaiting, 0);
        ryg = 3'b010;
        step(1);
        expect_now("rereq_set", carWaiting, 1);
        expect_now("rereq_count", detectCount, 2);

        // Arrival during green is held off until green falls.
        rawSensor = 1'b0;
        step(8);
        expect_now("arrive_left", sensorStable, 0);
        ryg = 3'b001;
        step(1);
        expect_now("arrive_served", carWaiting, 0);
        rawSensor = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step(1);
            expect_now("arrive_green_hold", carWaiting, 0);
        end
        expect_now("arrive_stable", sensorStable, 1);
        expect_now("arrive_count", detectCount, 3);
        ryg = 3'b100;
        step(1);
        expect_now("arrive_greenfall_set", carWaiting, 1);

        // Saturation: arrivals 4..260.
        for (int k = 0; k <= 256; k++) begin
            rawSensor = 1'b0;
            step(8);
            rawSensor = 1'b1;
            push((4 + k > 255) ? 255 : 4 + k);
            step(8);
            check("sat_count", detectCount);
        end
        expect_now("sat_carwait", carWaiting, 1);

        // Async reset in the middle of PEND_HIGH.
        rawSensor = 1'b0;
        step(8);
        expect_now("pend_pre_low", sensorStable, 0);
        rawSensor = 1'b1;
        step(4);
        expect_now("pend_cnt", dut.u_sync_debounce.cnt, 2);
        #2;
        reset_n = 1'b0;
        #1;
        expect_now("async_stable", sensorStable, 0);
        expect_now("async_carwait", carWaiting, 0);
        expect_now("async_count", detectCount, 0);
        expect_now("async_cnt", dut.u_sync_debounce.cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            step(1);
            push(n >= 6);
            check("rerelease_stable", sensorStable);
        end
        expect_now("rerelease_count", detectCount, 1);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
